graphic_instruction_loader: RTL and testbench
=============================================

Name: graphic_instruction_loader

Overview:
- Write-side controller for the 64-entry graphic instruction memory (64 chained graphic registers, 6-bit write address, 32-bit instruction, single write strobe).
- Accepts commands from the CPU/bus side over a valid/ready handshake: append, write-at-index, clear-all.
- Issues one memory write per cycle, and only during vertical blanking, so the pixel pipeline never sees a half-updated instruction list within a frame.
- Tracks the number of valid entries for software.

Parameters:
- DEPTH, 64, number of instruction slots; fixed to the memory's 6-bit address space.
- NULL_INSTRUCTION, 32'h0000_0000, word written to every slot by clear-all (disabled/transparent entry).
- SYNC_TO_BLANK, 1, 1 = writes gated by VBLANK; 0 = VBLANK ignored (treated as always high).

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- VBLANK  input  1  high while the raster is outside the visible area (synchronous to CLK)
- CMD_VALID  input  1  command present
- CMD_READY  output  1  loader can accept a command
- CMD_OP  input  2  00 APPEND, 01 WRITE_AT, 10 CLEAR_ALL, 11 reserved
- CMD_ADDR  input  6  slot index for WRITE_AT
- CMD_DATA  input  32  instruction word
- MEM_WRITE  output  1  write strobe to instruction memory
- MEM_ADDRESS  output  6  write address
- MEM_INSTRUCTION  output  32  write data
- COUNT  output  7  number of valid entries, 0..64
- FULL  output  1  COUNT == 64
- BUSY  output  1  state != IDLE
- ERR  output  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (async, RST=1): state IDLE, MEM_WRITE=0, MEM_ADDRESS=0, MEM_INSTRUCTION=0, COUNT=0, ERR=0, clear index=0. Any pending command is discarded.
- MEM_*, COUNT and ERR are registered. CMD_READY = (state==IDLE). FULL and BUSY are decoded from registers.
- Handshake: a command is accepted on a rising edge with CMD_VALID & CMD_READY. CMD_OP, CMD_ADDR and CMD_DATA are latched at that edge. CMD_VALID without READY has no effect; the source must hold the command.
- States: IDLE, PENDING, CLEAR.
- IDLE, on accept:
  - APPEND with FULL=1: ERR=1 next cycle, stay IDLE, no write.
  - Reserved op: ERR=1 next cycle, stay IDLE, no write.
  - APPEND (not full) or WRITE_AT: go to PENDING.
  - CLEAR_ALL: clear index=0, go to CLEAR.
- PENDING:
  - At each edge where VBLANK=1, issue the write:
    - MEM_WRITE=1 for exactly one cycle.
    - MEM_INSTRUCTION = latched data.
    - MEM_ADDRESS = COUNT[5:0] for APPEND, CMD_ADDR for WRITE_AT.
  - Return to IDLE at that same edge.
  - COUNT update at that edge: APPEND → COUNT+1; WRITE_AT → max(COUNT, CMD_ADDR+1).
  - While VBLANK=0: hold in PENDING, MEM_WRITE=0.
- Latency: accept at edge t0; with VBLANK high, MEM_WRITE is high during cycle t1–t2 and CMD_READY is high from t1. Best-case throughput is one command per 2 cycles.
- CLEAR:
  - Each edge with VBLANK=1: MEM_WRITE=1, MEM_ADDRESS=index, MEM_INSTRUCTION=NULL_INSTRUCTION, index+1.
  - Edges with VBLANK=0: MEM_WRITE=0, index held. The clear pauses across visible lines and resumes at the next blanking.
  - After the write of index 63 is issued: COUNT=0, go to IDLE. Total: exactly 64 strobes, addresses 0..63 ascending, no duplicates or gaps.
  - COUNT keeps its old value until the clear completes.
- MEM_ADDRESS and MEM_INSTRUCTION hold their last values when MEM_WRITE=0.
- COUNT saturates at 64. APPEND never wraps the address. WRITE_AT to any index is legal even when FULL.
- VBLANK dropping in the same cycle a write is due: the sampled edge value decides; no partial writes exist.
- RST asserted mid-CLEAR or mid-PENDING: immediate return to reset state. The partial clear is not resumed; memory contents are the memory's own reset responsibility.

Test Plan:
- Reset, VBLANK=1, APPEND data 32'hA5A5_0001 → one MEM_WRITE pulse, address 0, data A5A5_0001, one cycle after accept; COUNT=1, ERR=0.
- 64 APPENDs with VBLANK=1 → addresses 0..63 in order, COUNT=64, FULL=1; 65th APPEND → ERR pulse, no MEM_WRITE, COUNT stays 64.
- VBLANK=0, APPEND accepted → BUSY=1, CMD_READY=0, no write for 20 cycles; raise VBLANK → single write at address COUNT, then READY=1.
- COUNT=3, WRITE_AT addr 10, data 32'h0000_BEEF → write at address 10; COUNT=11. Then WRITE_AT addr 2 → COUNT stays 11.
- CLEAR_ALL with VBLANK toggling 1 for 10 cycles, 0 for 30, 1 thereafter → exactly 64 strobes, addresses 0..63 ascending, data NULL_INSTRUCTION, none during VBLANK=0; COUNT=0 after the last strobe.
- RST pulse after 20 clear writes → outputs at reset values asynchronously, state IDLE, COUNT=0; reserved op 2'b11 afterwards → ERR pulse, no write.

Source files
------------

// File: rtl/graphic_instruction_loader.sv
// Write-side loader for the 64-slot graphic instruction memory.
// Commands are queued one at a time and committed only during vertical blanking.
module graphic_instruction_loader #(
    parameter int          DEPTH            = 64,
    parameter logic [31:0] NULL_INSTRUCTION = 32'h0000_0000,
    parameter bit          SYNC_TO_BLANK    = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VBLANK,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [5:0]  CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_INSTRUCTION,
    output logic [6:0]  COUNT,
    output logic        FULL,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    localparam logic [1:0] OP_APPEND = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    localparam logic [6:0] CNT_MAX  = 7'(DEPTH);
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

    state_t      state_q;
    logic [1:0]  op_q;
    logic [5:0]  addr_q;
    logic [31:0] data_q;
    logic [5:0]  clr_idx_q;
    logic [6:0]  count_q;
    logic        mem_write_q;
    logic [5:0]  mem_addr_q;
    logic [31:0] mem_instr_q;
    logic        err_q;

    logic       blank;
    logic       full_w;
    logic [6:0] wa_cnt;
    logic [6:0] wa_next;
    logic [6:0] ap_next;

    assign blank   = SYNC_TO_BLANK ? VBLANK : 1'b1;
    assign full_w  = (count_q == CNT_MAX);
    assign wa_cnt  = {1'b0, addr_q} + 7'd1;
    assign wa_next = (wa_cnt > count_q) ? wa_cnt : count_q;
    assign ap_next = full_w ? count_q : count_q + 7'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            op_q        <= OP_APPEND;
            addr_q      <= '0;
            data_q      <= '0;
            clr_idx_q   <= '0;
            count_q     <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_instr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (CMD_VALID) begin
                        op_q   <= CMD_OP;
                        addr_q <= CMD_ADDR;
                        data_q <= CMD_DATA;
                        unique case (CMD_OP)
                            OP_APPEND: begin
                                if (full_w) err_q   <= 1'b1;
                                else        state_q <= PENDING;
                            end
                            OP_WRITE: state_q <= PENDING;
                            OP_CLEAR: begin
                                clr_idx_q <= '0;
                                state_q   <= CLEAR;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                PENDING: begin
                    if (blank) begin
                        mem_write_q <= 1'b1;
                        mem_instr_q <= data_q;
                        state_q     <= IDLE;
                        if (op_q == OP_APPEND) begin
                            mem_addr_q <= count_q[5:0];
                            count_q    <= ap_next;
                        end else begin
                            mem_addr_q <= addr_q;
                            count_q    <= wa_next;
                        end
                    end
                end
                CLEAR: begin
                    // Index only advances on blanking edges, so a clear
                    // spanning visible lines resumes where it paused.
                    if (blank) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= clr_idx_q;
                        mem_instr_q <= NULL_INSTRUCTION;
                        clr_idx_q   <= clr_idx_q + 6'd1;
                        if (clr_idx_q == LAST_IDX) begin
                            count_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CMD_READY       = (state_q == IDLE);
    assign BUSY            = (state_q != IDLE);
    assign FULL            = full_w;
    assign COUNT           = count_q;
    assign ERR             = err_q;
    assign MEM_WRITE       = mem_write_q;
    assign MEM_ADDRESS     = mem_addr_q;
    assign MEM_INSTRUCTION = mem_instr_q;

endmodule

// File: tb/tb_graphic_instruction_loader.sv
// Bench for graphic_instruction_loader: queue-based write model
// checked every cycle, plus directed literal scenarios.
module tb_graphic_instruction_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        VBLANK = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'b00;
    logic [5:0]  CMD_ADDR = '0;
    logic [31:0] CMD_DATA = '0;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_INSTRUCTION;
    logic [6:0]  COUNT;
    logic        FULL;
    logic        BUSY;
    logic        ERR;

    graphic_instruction_loader dut (
        .CLK(CLK), .RST(RST), .VBLANK(VBLANK),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_INSTRUCTION(MEM_INSTRUCTION), .COUNT(COUNT),
        .FULL(FULL), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    bit rand_vb = 1'b0;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted command becomes a list of memory writes
    // drained one per blanking edge; nc = COUNT after that write (-1 keep).
    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          nc;
    } wr_t;

    wr_t         q[$];
    int          m_cnt = 0;
    bit          m_wr = 0;
    bit          m_err = 0;
    logic [5:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            m_cnt = 0; m_wr = 0; m_err = 0;
            m_addr = '0; m_data = '0;
        end else begin
            m_wr = 0;
            m_err = 0;
            if (q.size() > 0) begin
                if (VBLANK) begin
                    wr_t e;
                    e = q.pop_front();
                    m_wr = 1;
                    m_addr = e.a;
                    m_data = e.d;
                    if (e.nc >= 0) m_cnt = e.nc;
                end
            end else if (CMD_VALID) begin
                case (CMD_OP)
                    2'b00: begin
                        if (m_cnt == 64) m_err = 1;
                        else q.push_back('{6'(m_cnt), CMD_DATA, m_cnt + 1});
                    end
                    2'b01: begin
                        int n;
                        n = int'(CMD_ADDR) + 1;
                        q.push_back('{CMD_ADDR, CMD_DATA, (n > m_cnt) ? n : m_cnt});
                    end
                    2'b10: begin
                        for (int i = 0; i < 64; i++)
                            q.push_back('{6'(i), 32'h0, (i == 63) ? 0 : -1});
                    end
                    default: m_err = 1;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        bit busy;
        busy = (q.size() > 0);
        check(MEM_WRITE == m_wr, "mem_write", MEM_WRITE, m_wr);
        check(MEM_ADDRESS == m_addr, "mem_address", MEM_ADDRESS, m_addr);
        check(MEM_INSTRUCTION == m_data, "mem_instr", MEM_INSTRUCTION, m_data);
        check(COUNT == 7'(m_cnt), "count", COUNT, m_cnt);
        check(FULL == (m_cnt == 64), "full", FULL, m_cnt == 64);
        check(BUSY == busy, "busy", BUSY, busy);
        check(CMD_READY == !busy, "ready", CMD_READY, !busy);
        check(ERR == m_err, "err", ERR, m_err);
    end

    always @(negedge CLK) begin
        #1;
        if (rand_vb) VBLANK = ($urandom_range(0, 9) < 6);
    end

    task automatic send(input logic [1:0] op, input logic [5:0] a,
                        input logic [31:0] d);
        int n = 0;
        @(negedge CLK); #1;
        CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_DATA = d;
        while (!CMD_READY && n < 5000) begin
            @(negedge CLK); #1;
            n++;
        end
        if (n >= 5000) check(1'b0, "send_timeout", n, 0);
        @(negedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 5000) begin
            @(negedge CLK); #1;
            n++;
        end
        if (n >= 5000) check(1'b0, "idle_timeout", n, 0);
    endtask

    initial begin
        int strobes;
        int n;
        repeat (2) @(negedge CLK);
        #1;
        check(COUNT == 0 && !MEM_WRITE && !ERR && CMD_READY, "reset_state", COUNT, 0);
        RST = 1'b0;

        // Single append: write one cycle after accept
        send(2'b00, 6'd0, 32'hA5A5_0001);
        check(MEM_WRITE == 1'b0 && BUSY, "lat_pending", MEM_WRITE, 0);
        @(negedge CLK);
        check(MEM_WRITE && MEM_ADDRESS == 0, "first_write", MEM_ADDRESS, 0);
        check(MEM_INSTRUCTION == 32'hA5A5_0001, "first_data", MEM_INSTRUCTION, 32'hA5A5_0001);
        check(COUNT == 1 && CMD_READY && !ERR, "first_count", COUNT, 1);

        // Fill to 64, then overflow append
        for (int i = 1; i < 64; i++) send(2'b00, 6'd0, $urandom);
        wait_idle();
        check(COUNT == 64 && FULL, "full_64", COUNT, 64);
        send(2'b00, 6'd0, 32'hDEAD_0000);
        check(ERR && !MEM_WRITE, "overflow_err", ERR, 1);
        check(COUNT == 64, "overflow_count", COUNT, 64);

        // Clear with VBLANK 10 high / 30 low / high
        send(2'b10, 6'd0, 32'h0);
        strobes = 0;
        n = 0;
        while (strobes < 64 && n < 300) begin
            bit vb;
            vb = (n < 10) || (n >= 40);
            VBLANK = vb;
            @(negedge CLK);
            if (MEM_WRITE) begin
                check(vb, "clear_in_blank", vb, 1);
                check(MEM_ADDRESS == 6'(strobes), "clear_addr", MEM_ADDRESS, strobes);
                strobes++;
            end
            #1;
            n++;
        end
        check(strobes == 64, "clear_strobes", strobes, 64);
        check(COUNT == 0 && !BUSY, "clear_count", COUNT, 0);

        // Append held off by visible area
        VBLANK = 1'b0;
        send(2'b00, 6'd0, 32'h1234_5678);
        n = 0;
        repeat (20) begin
            @(negedge CLK);
            if (BUSY && !CMD_READY && !MEM_WRITE) n++;
            #1;
        end
        check(n == 20, "hold_20", n, 20);
        VBLANK = 1'b1;
        @(negedge CLK);
        check(MEM_WRITE && MEM_ADDRESS == 0, "held_write", MEM_ADDRESS, 0);
        check(CMD_READY, "held_ready", CMD_READY, 1);

        // WRITE_AT count extension
        send(2'b00, 6'd0, 32'h1);
        send(2'b00, 6'd0, 32'h2);
        wait_idle();
        check(COUNT == 3, "count_3", COUNT, 3);
        send(2'b01, 6'd10, 32'h0000_BEEF);
        @(negedge CLK);
        check(MEM_WRITE && MEM_ADDRESS == 10 && MEM_INSTRUCTION == 32'hBEEF,
              "write_at_10", MEM_ADDRESS, 10);
        check(COUNT == 11, "count_11", COUNT, 11);
        send(2'b01, 6'd2, 32'h0000_CAFE);
        wait_idle();
        check(COUNT == 11, "count_stays_11", COUNT, 11);

        // Randomised traffic
        rand_vb = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(0, 99);
            op = (r < 50) ? 2'b00 : (r < 88) ? 2'b01 : (r < 92) ? 2'b10 : 2'b11;
            send(op, 6'($urandom), $urandom);
        end
        wait_idle();
        rand_vb = 1'b0;
        @(negedge CLK); #1;
        VBLANK = 1'b1;

        // Reset in the middle of a clear
        send(2'b10, 6'd0, 32'h0);
        strobes = 0;
        n = 0;
        while (strobes < 20 && n < 200) begin
            @(negedge CLK);
            if (MEM_WRITE) strobes++;
            #1;
            n++;
        end
        check(strobes == 20, "pre_reset_strobes", strobes, 20);
        RST = 1'b1;
        #1;
        check(!MEM_WRITE && MEM_ADDRESS == 0 && MEM_INSTRUCTION == 0,
              "async_mem", MEM_ADDRESS, 0);
        check(COUNT == 0 && !BUSY && CMD_READY && !ERR, "async_state", COUNT, 0);
        @(negedge CLK); #1;
        RST = 1'b0;
        send(2'b11, 6'd5, 32'hFFFF_FFFF);
        check(ERR && !MEM_WRITE && !BUSY, "reserved_err", ERR, 1);
        repeat (3) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
